// File: rtl/register_bank_param_pkg.sv
// Shared encodings and default sizes for the parametrised register bank.
package register_bank_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_SWAP = 2'b11
  } write_op_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_REGS   = 8;

endpackage

// File: rtl/register_bank_param_if.sv
// Control and read-port bundle between the datapath and the register bank.
interface register_bank_param_if #(
  parameter int DATA_WIDTH = register_bank_pkg::DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = register_bank_pkg::DEFAULT_NUM_REGS,
  parameter int SEL_WIDTH  = $clog2(NUM_REGS)
);

  logic                          write_en;
  register_bank_pkg::write_op_t  write_op;
  logic                          read_en;
  logic [SEL_WIDTH-1:0]          in_rx_selector;
  logic [SEL_WIDTH-1:0]          in_ry_selector;
  logic [DATA_WIDTH-1:0]         in_data;
  logic [DATA_WIDTH-1:0]         out_rx_data;
  logic [DATA_WIDTH-1:0]         out_ry_data;
  logic                          out_zero;
  logic                          out_carry;

  modport slave (
    input  write_en, write_op, read_en, in_rx_selector, in_ry_selector, in_data,
    output out_rx_data, out_ry_data, out_zero, out_carry
  );

  modport master (
    output write_en, write_op, read_en, in_rx_selector, in_ry_selector, in_data,
    input  out_rx_data, out_ry_data, out_zero, out_carry
  );

endinterface

// File: rtl/register_bank_param_alu.sv
// Combinational next-value unit for the Rx write path: load, inc, dec or swap-in.
module reg_bank_alu
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  write_op_t             i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_next,
  output logic                  o_carry,
  output logic                  o_zero
);

  logic [DATA_WIDTH:0] w_ext;

  always_comb begin
    w_ext   = '0;
    o_next  = i_a;
    o_carry = 1'b0;
    case (i_op)
      OP_LOAD: o_next = i_data;
      OP_INC: begin
        w_ext   = {1'b0, i_a} + (DATA_WIDTH+1)'(1);
        o_next  = w_ext[DATA_WIDTH-1:0];
        o_carry = w_ext[DATA_WIDTH];
      end
      OP_DEC: begin
        // The extra top bit goes high only on the 0 -> all-ones wrap (borrow).
        w_ext   = {1'b0, i_a} - (DATA_WIDTH+1)'(1);
        o_next  = w_ext[DATA_WIDTH-1:0];
        o_carry = w_ext[DATA_WIDTH];
      end
      OP_SWAP: o_next = i_b;
      default: o_next = i_a;
    endcase
  end

  assign o_zero = (o_next == '0);

endmodule

// File: rtl/register_bank_param.sv
// Parametrised general register bank: two combinational read ports, tri-state
// bus read of Ry, load/inc/dec/swap writes and registered zero/carry flags.
module register_bank_param
  import register_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    NUM_REGS    = DEFAULT_NUM_REGS,
  parameter int                    SEL_WIDTH   = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    ZERO_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  register_bank_param_if.slave  bus_if,
  output wire [DATA_WIDTH-1:0]  out_bus_data
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_zero;
  logic                  r_carry;

  logic [NUM_REGS-1:0]   w_rx_hit;
  logic [NUM_REGS-1:0]   w_ry_hit;
  logic                  w_rx_ok;
  logic                  w_is_swap;
  logic [DATA_WIDTH-1:0] w_rx_data;
  logic [DATA_WIDTH-1:0] w_ry_data;
  logic [DATA_WIDTH-1:0] w_alu_next;
  logic                  w_alu_carry;
  logic                  w_alu_zero;

  // Write-target decode; a hardwired R0 never matches, and out-of-range
  // selectors match nothing, so such writes drop out naturally.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
      localparam bit LP_WRITABLE = !((ZERO_REG != 0) && (gi == 0));
      assign w_rx_hit[gi] = LP_WRITABLE && (bus_if.in_rx_selector == SEL_WIDTH'(gi));
      assign w_ry_hit[gi] = LP_WRITABLE && (bus_if.in_ry_selector == SEL_WIDTH'(gi));
    end
  endgenerate

  assign w_rx_ok   = |w_rx_hit;
  assign w_is_swap = (bus_if.write_op == OP_SWAP);

  // A hardwired R0 is held at zero in storage, so only the range check is needed.
  assign w_rx_data = (int'(bus_if.in_rx_selector) < NUM_REGS) ? r_regs[bus_if.in_rx_selector] : '0;
  assign w_ry_data = (int'(bus_if.in_ry_selector) < NUM_REGS) ? r_regs[bus_if.in_ry_selector] : '0;

  reg_bank_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_op    (bus_if.write_op),
    .i_a     (w_rx_data),
    .i_b     (w_ry_data),
    .i_data  (bus_if.in_data),
    .o_next  (w_alu_next),
    .o_carry (w_alu_carry),
    .o_zero  (w_alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : RESET_VALUE;
      end
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (bus_if.write_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_rx_hit[i]) begin
          r_regs[i] <= w_alu_next;
        end else if (w_is_swap && w_ry_hit[i]) begin
          r_regs[i] <= w_rx_data;
        end
      end
      // A discarded write leaves zero as the effective stored value.
      r_zero  <= w_rx_ok ? w_alu_zero : 1'b1;
      r_carry <= w_alu_carry;
    end
  end

  assign bus_if.out_rx_data = w_rx_data;
  assign bus_if.out_ry_data = w_ry_data;
  assign bus_if.out_zero    = r_zero;
  assign bus_if.out_carry   = r_carry;

  assign out_bus_data = bus_if.read_en ? w_ry_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_register_bank_param.sv
// Two bank configurations (8 regs plain, 6 regs with hardwired R0) driven in
// lockstep and compared against a behavioural model through a scoreboard.
module tb_register_bank_param;
  import register_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [1:0] op = 2'b00;
  logic [2:0] rx = 3'd0;
  logic [2:0] ry = 3'd0;
  logic [7:0] data = 8'h00;
  wire  [7:0] bus_a;
  wire  [7:0] bus_b;

  always #5 clk = ~clk;

  register_bank_param_if #(.DATA_WIDTH(8), .NUM_REGS(8)) if_a ();
  register_bank_param_if #(.DATA_WIDTH(8), .NUM_REGS(6)) if_b ();

  assign if_a.write_en       = we;
  assign if_a.write_op       = write_op_t'(op);
  assign if_a.read_en        = re;
  assign if_a.in_rx_selector = rx;
  assign if_a.in_ry_selector = ry;
  assign if_a.in_data        = data;
  assign if_b.write_en       = we;
  assign if_b.write_op       = write_op_t'(op);
  assign if_b.read_en        = re;
  assign if_b.in_rx_selector = rx;
  assign if_b.in_ry_selector = ry;
  assign if_b.in_data        = data;

  register_bank_param #(
    .DATA_WIDTH(8), .NUM_REGS(8), .RESET_VALUE(8'h5A), .ZERO_REG(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus_if(if_a.slave), .out_bus_data(bus_a)
  );

  register_bank_param #(
    .DATA_WIDTH(8), .NUM_REGS(6), .RESET_VALUE(8'h5A), .ZERO_REG(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus_if(if_b.slave), .out_bus_data(bus_b)
  );

  typedef struct packed {
    logic [7:0] rx_a, ry_a, rx_b, ry_b;
    logic       z_a, c_a, z_b, c_b, re;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [7:0] mdl [2][8];
  logic       zf [2];
  logic       cf [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic int nregs(input bit b);
    return b ? 6 : 8;
  endfunction

  function automatic bit writable(input bit b, input logic [2:0] s);
    return (int'(s) < nregs(b)) && !(b && (s == 3'd0));
  endfunction

  function automatic logic [7:0] mread(input bit b, input logic [2:0] s);
    if (int'(s) >= nregs(b)) return 8'h00;
    return mdl[b][s];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) mdl[b][i] = (b == 1 && i == 0) ? 8'h00 : 8'h5A;
      zf[b] = 1'b0;
      cf[b] = 1'b0;
    end
  endtask

  task automatic model_write(input bit b);
    logic [7:0] a, o, v;
    logic [8:0] ext;
    logic       c;
    a = mread(b, rx);
    o = mread(b, ry);
    v = data;
    c = 1'b0;
    case (op)
      2'b01: begin ext = {1'b0, a} + 9'd1; v = ext[7:0]; c = ext[8]; end
      2'b10: begin ext = {1'b0, a} - 9'd1; v = ext[7:0]; c = ext[8]; end
      2'b11: v = o;
      default: v = data;
    endcase
    if (writable(b, rx)) mdl[b][rx] = v;
    if (op == 2'b11 && writable(b, ry)) mdl[b][ry] = a;
    zf[b] = writable(b, rx) ? (v == 8'h00) : 1'b1;
    cf[b] = c;
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, "/rx_a"}, if_a.out_rx_data, e.rx_a);
    check({t, "/ry_a"}, if_a.out_ry_data, e.ry_a);
    check({t, "/zero_a"}, {7'd0, if_a.out_zero}, {7'd0, e.z_a});
    check({t, "/carry_a"}, {7'd0, if_a.out_carry}, {7'd0, e.c_a});
    check({t, "/rx_b"}, if_b.out_rx_data, e.rx_b);
    check({t, "/ry_b"}, if_b.out_ry_data, e.ry_b);
    check({t, "/zero_b"}, {7'd0, if_b.out_zero}, {7'd0, e.z_b});
    check({t, "/carry_b"}, {7'd0, if_b.out_carry}, {7'd0, e.c_b});
    if (e.re) begin
      check({t, "/bus_a"}, bus_a, e.ry_a);
      check({t, "/bus_b"}, bus_b, e.ry_b);
    end else begin
      // Undriven bus: accept Z, or 0 where the simulator resolves Z to 0.
      check({t, "/bus_a_z"}, {7'd0, (bus_a === 8'hzz) || (bus_a === 8'h00)}, 8'h01);
      check({t, "/bus_b_z"}, {7'd0, (bus_b === 8'hzz) || (bus_b === 8'h00)}, 8'h01);
    end
  endtask

  task automatic step(input string tag, input bit rst_i, input bit we_i, input logic [1:0] op_i,
                      input logic [2:0] rx_i, input logic [2:0] ry_i, input logic [7:0] d_i,
                      input bit re_i, input bit edge_i);
    exp_t e;
    @(negedge clk);
    rst = rst_i; we = we_i; op = op_i; rx = rx_i; ry = ry_i; data = d_i; re = re_i;
    if (edge_i) begin
      if (rst_i) model_reset();
      else if (we_i) begin
        model_write(1'b0);
        model_write(1'b1);
      end
    end
    e.rx_a = mread(1'b0, rx_i); e.ry_a = mread(1'b0, ry_i);
    e.rx_b = mread(1'b1, rx_i); e.ry_b = mread(1'b1, ry_i);
    e.z_a = zf[0]; e.c_a = cf[0]; e.z_b = zf[1]; e.c_b = cf[1];
    e.re = re_i;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    if (edge_i) begin
      @(posedge clk);
      #1;
    end else begin
      #1;
    end
    $display("txn %-10s rst=%0d we=%0d op=%0d rx=%0d ry=%0d d=%h re=%0d", tag, rst_i, we_i, op_i, rx_i, ry_i, d_i, re_i);
    compare_out();
  endtask

  initial begin
    // Reset, then every register visible through both read ports.
    step("reset", 1, 0, OP_LOAD, 3'd0, 3'd1, 8'h00, 0, 1);
    for (int s = 0; s < 8; s++) step($sformatf("rst_rd%0d", s), 0, 0, OP_LOAD, 3'(s), 3'(7 - s), 8'h00, 0, 0);

    // Loads and bus read.
    step("ld_r4", 0, 1, OP_LOAD, 3'd4, 3'd4, 8'hAA, 0, 1);
    step("ld_r0", 0, 1, OP_LOAD, 3'd0, 3'd0, 8'hFF, 1, 1);
    step("bus_off", 0, 0, OP_LOAD, 3'd0, 3'd0, 8'h00, 0, 0);
    step("rd_r4", 0, 0, OP_LOAD, 3'd4, 3'd0, 8'h00, 1, 0);

    // Increment/decrement wraps.
    step("ld_r2", 0, 1, OP_LOAD, 3'd2, 3'd2, 8'hFF, 0, 1);
    step("inc_r2", 0, 1, OP_INC, 3'd2, 3'd2, 8'h00, 0, 1);
    step("dec_r2a", 0, 1, OP_DEC, 3'd2, 3'd2, 8'h00, 0, 1);
    step("dec_r2b", 0, 1, OP_DEC, 3'd2, 3'd2, 8'h00, 1, 1);
    step("hold", 0, 0, 2'bxx, 3'd2, 3'd2, 8'h00, 0, 1);

    // Swaps.
    step("ld_r1", 0, 1, OP_LOAD, 3'd1, 3'd1, 8'h11, 0, 1);
    step("ld_r3", 0, 1, OP_LOAD, 3'd3, 3'd3, 8'h33, 0, 1);
    step("inc_r3", 0, 1, OP_INC, 3'd3, 3'd3, 8'h00, 0, 1);
    step("dec_r3", 0, 1, OP_DEC, 3'd3, 3'd3, 8'h00, 0, 1);
    step("swp_1_3", 0, 1, OP_SWAP, 3'd1, 3'd3, 8'h00, 1, 1);
    step("swp_3_3", 0, 1, OP_SWAP, 3'd3, 3'd3, 8'h00, 0, 1);

    // Hardwired R0 behaviour on the second bank.
    step("ld77_r0", 0, 1, OP_LOAD, 3'd0, 3'd0, 8'h77, 0, 1);
    step("ld_r5", 0, 1, OP_LOAD, 3'd5, 3'd5, 8'h09, 0, 1);
    step("swp_5_0", 0, 1, OP_SWAP, 3'd5, 3'd0, 8'h00, 1, 1);
    step("inc_r0", 0, 1, OP_INC, 3'd0, 3'd5, 8'h00, 0, 1);
    step("dec_r0", 0, 1, OP_DEC, 3'd0, 3'd5, 8'h00, 0, 1);

    // Reset beats a simultaneous write; out-of-range selectors.
    step("rst_wr", 1, 1, OP_LOAD, 3'd6, 3'd6, 8'hC3, 0, 1);
    step("ld_sel7", 0, 1, OP_LOAD, 3'd7, 3'd7, 8'h3C, 1, 1);
    step("inc_sel7", 0, 1, OP_INC, 3'd7, 3'd7, 8'h00, 0, 1);
    step("dec_sel6", 0, 1, OP_DEC, 3'd6, 3'd7, 8'h00, 0, 1);
    step("swp_4_7", 0, 1, OP_SWAP, 3'd4, 3'd7, 8'h00, 1, 1);
    for (int s = 0; s < 8; s++) step($sformatf("scan%0d", s), 0, 0, OP_LOAD, 3'(s), 3'(7 - s), 8'h00, 1, 0);

    // Random mix.
    for (int n = 0; n < 60; n++) begin
      step($sformatf("rnd%0d", n), 0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)), 1);
    end

    @(negedge clk);
    we = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_bank_param.md
Name: register_bank_param

Overview:
- Parametrised successor to the 8x8 register bank. Holds NUM_REGS general registers of DATA_WIDTH bits each.
- Two combinational read ports (Rx, Ry) and a tri-state bus read of Ry.
- One write path with four operations: load, increment, decrement, swap.
- Registered zero and carry flags feed the control unit's branch logic.
- Sits between the datapath bus and the ALU operand inputs.

Parameters:
DATA_WIDTH, 8, register and bus width in bits (>=2)
NUM_REGS, 8, number of registers (2..256; need not be a power of 2)
SEL_WIDTH, $clog2(NUM_REGS), selector width; derived, do not override
RESET_VALUE, 0, value loaded into every register on reset
ZERO_REG, 0, 1 = R0 is hardwired to zero and ignores writes

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
write_en  in  1  perform write_op on this rising edge
write_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 SWAP
read_en  in  1  drive out_bus_data with Ry contents
in_rx_selector  in  SEL_WIDTH  destination / first operand register index
in_ry_selector  in  SEL_WIDTH  second operand / bus source register index
in_data  in  DATA_WIDTH  load data
out_rx_data  out  DATA_WIDTH  combinational read of R[rx]
out_ry_data  out  DATA_WIDTH  combinational read of R[ry]
out_bus_data  out  DATA_WIDTH  R[ry] when read_en, else all-Z
out_zero  out  1  registered zero flag
out_carry  out  1  registered carry/borrow flag

Behaviour:
- Reset:
  - All registers are set to RESET_VALUE; R0 is set to 0 when ZERO_REG=1.
  - out_zero and out_carry are set to 0.
  - rst has priority over write_en on the same edge.
- Reads:
  - Combinational from storage; zero latency to a selector change.
  - No write forwarding: a written value appears on the read ports just after the rising edge that commits it.
- Bus:
  - out_bus_data follows out_ry_data combinationally while read_en=1.
  - It is all-Z while read_en=0, including during reset.
- Writes occur on a rising edge with write_en=1 and rst=0:
  - LOAD: R[rx] <= in_data.
  - INC: R[rx] <= R[rx]+1 modulo 2^DATA_WIDTH. Carry = carry-out, set only when wrapping from all-ones to 0.
  - DEC: R[rx] <= R[rx]-1 modulo 2^DATA_WIDTH. Carry = borrow, set only when wrapping from 0 to all-ones.
  - SWAP: R[rx] <= old R[ry] and R[ry] <= old R[rx] on the same edge, using pre-edge values. rx==ry leaves the register unchanged.
- Flags:
  - Updated only on edges where a write executes; otherwise they hold.
  - out_zero = (value stored into R[rx] after the edge == 0).
  - out_carry is computed for INC/DEC and cleared to 0 for LOAD and SWAP.
- ZERO_REG=1:
  - R0 always reads 0, and any write targeting R0 is discarded.
  - SWAP with R0 still writes 0 into the other register.
  - Flags reflect the value actually stored, so any write to R0 sets out_zero=1. INC/DEC on R0 compute carry from 0 (INC 0, DEC 1).
- Selectors >= NUM_REGS:
  - Reads return 0.
  - Writes to that index are discarded; a SWAP partner still receives 0.
  - Flags are computed as for ZERO_REG writes to R0.
- write_op is sampled only when write_en=1. An X/unused value while write_en=0 has no effect.

Decomposition:
- Shared package register_bank_pkg:
  - write_op encodings OP_LOAD, OP_INC, OP_DEC, OP_SWAP.
  - Default DATA_WIDTH and NUM_REGS constants.
- One sub-module, reg_bank_alu: a purely combinational INC/DEC/pass unit. It returns the next value, carry and zero for the Rx write path, which keeps flag logic out of the storage array.

Test Plan:
1. Assert rst=1 for one edge with RESET_VALUE=8'h5A -> every register reads 8'h5A, out_zero=0, out_carry=0, out_bus_data=8'hZZ.
2. LOAD 8'hAA into R4, then LOAD 8'hFF into R0 (ZERO_REG=0), set ry=0, read_en=1 -> out_rx_data=8'hFF, out_ry_data=8'hFF, bus=8'hFF; drop read_en -> bus=8'hZZ.
3. LOAD 8'hFF into R2, then INC R2 -> R2=8'h00, zero=1, carry=1; DEC R2 -> R2=8'hFF, zero=0, carry=1; DEC R2 -> R2=8'hFE, carry=0.
4. R1=8'h11, R3=8'h33, SWAP rx=1 ry=3 -> R1=8'h33, R3=8'h11 after one edge, carry=0; SWAP rx=ry=3 -> R3 stays 8'h11.
5. ZERO_REG=1: LOAD 8'h77 into R0 -> R0 reads 0, zero=1; R5=8'h09, SWAP rx=5 ry=0 -> R5=0, R0=0.
6. Reset priority: write_en=1 with LOAD 8'hC3 into R6 and rst=1 on the same edge -> R6=RESET_VALUE, flags 0; with NUM_REGS=6, LOAD to selector 7 -> no register changes, read of selector 7 returns 0.
